ul_decompress_bit: RTL and testbench
====================================

Name: ul_decompress_bit

Overview:
- Uplink block-floating-point decompressor, the inverse of the per-PRB compressor on the PUSCH path.
- Takes NUM-bit I/Q mantissas plus one 4-bit block exponent (shift) per PRB packet, and rebuilds 16-bit signed I/Q samples.
- Sits after the fronthaul/DR unpack, in front of channel-estimation consumers.
- Checks packet framing, counts errors, and delays all sideband fields to stay aligned with the data.

Parameters:
- NUM, 7, mantissa width per component; legal range 2..15.
- PRB_LEN, 12, required valid samples per packet (sop to eop inclusive).
- MAX_SHIFT, 9, largest legal exponent; larger values are clamped to it.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_sel  in  1  antenna/stream select, passed through.
- i_sop  in  1  packet start; qualified by i_vld.
- i_eop  in  1  packet end; qualified by i_vld.
- i_vld  in  1  sample valid.
- i_din  in  2*NUM  {I mantissa, Q mantissa}, each two's complement.
- i_shift  in  4  block exponent; sampled only on i_vld&i_sop.
- i_slot_idx  in  7  passed through.
- i_symb_idx  in  4  passed through.
- i_prb_idx  in  9  passed through.
- i_ch_type  in  4  passed through.
- i_info  in  8  passed through.
- o_sel, o_sop, o_eop, o_vld  out  1 each  delayed copies of the inputs.
- o_dout  out  32  {I[15:0], Q[15:0]}, reconstructed samples.
- o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info  out  7/4/9/4/8  delayed sideband.
- o_err  out  1  framing-error pulse, aligned with the offending o_vld beat.
- o_err_cnt  out  16  saturating count of framing errors.

Behaviour:
- Latency: fixed 3 clk from input to output for every output except o_err_cnt.
  - Stage 1: register the inputs and resolve the exponent.
  - Stage 2: expand and shift.
  - Stage 3: output register.
  - Sideband and control use an identical 3-deep shift register, so output alignment is independent of the data path.
- Reset: all outputs clear to 0. FSM goes to IDLE. Exponent register = 0. Sample counter = 0. o_err_cnt = 0.
- Arithmetic, applied per component:
  - Form e = {mantissa, (16-NUM) zeros}.
  - Result = e >>> shift_eff, arithmetic (sign-propagating).
  - No rounding bias is added.
  - The result always fits in 16 bits; no saturation is needed.
- o_dout = 0 whenever the delayed o_vld = 0.
- Exponent handling:
  - shift_eff is latched on i_vld&i_sop.
  - An i_shift value > MAX_SHIFT latches MAX_SHIFT and flags an error on that beat.
  - The sop beat itself is decoded with the newly sampled exponent, not the previously held one.
- FSM states: IDLE and BODY; cnt is 5 bits.
  - IDLE, i_vld&i_sop&!i_eop: go to BODY, cnt = 1.
  - IDLE, i_vld&i_sop&i_eop: stay in IDLE. This is an error if PRB_LEN != 1.
  - IDLE, i_vld without i_sop: error (orphan sample). The sample is decoded with the held exponent; the FSM stays in IDLE.
  - BODY, i_vld&!i_sop&!i_eop: cnt++. If cnt would exceed PRB_LEN, flag an error and saturate cnt.
  - BODY, i_vld&i_eop: go to IDLE. If cnt+1 != PRB_LEN, flag an error.
  - BODY, i_vld&i_sop: error (missing eop). Restart the packet: latch the new exponent, cnt = 1, stay in BODY. If i_eop is also set, go to IDLE instead.
  - i_vld = 0: no state change. Gaps inside a packet are legal.
  - i_sop/i_eop without i_vld: ignored.
- Error reporting:
  - Multiple error causes on one beat produce a single o_err pulse and a single count increment.
  - o_err_cnt increments in stage 3 together with o_err.
  - o_err_cnt saturates at 16'hFFFF.
- rst mid-packet: the pipeline is flushed, so the next 3 outputs are 0. The FSM returns to IDLE. The next beat is handled as a fresh packet start or as an orphan.

Test Plan:
- NUM=7, 12-beat packet, shift=0, I=7'h3F, Q=7'h40 -> o_dout = {16'h7E00, 16'h8000}. o_vld is high 3 clk after each i_vld. o_sop/o_eop are aligned. o_err stays 0.
- Same mantissas with shift=3 -> {16'h0FC0, 16'hF000}. Then mantissa 7'h01 with shift=9 -> 16'h0001, and 7'h7F with shift=9 -> 16'hFFFF.
- Back-to-back packets with shifts 2 then 5 and no idle gap -> the first packet's beats use shift 2 (7'h3F gives 16'h1F80). The second packet's sop beat already uses shift 5 (16'h03F0).
- Framing errors:
  - 11-beat packet -> one o_err pulse on the eop beat, o_err_cnt = 1.
  - sop inside BODY -> o_err on that beat, and the packet restarts.
  - Orphan vld in IDLE -> o_err pulse; the count reaches 3.
- i_shift = 4'hC on sop -> decoded as shift 9, o_err pulses once. Vld gaps of 1 to 4 clk mid-packet -> no error, and o_vld reproduces the exact gap pattern.
- rst asserted at beat 6 of a packet -> all outputs 0 from the following cycle, o_err_cnt = 0. A new complete packet afterwards decodes correctly with no error.

Source files
------------

// File: rtl/ul_decompress_bit.sv
// Uplink block-floating-point decompressor: rebuilds 16-bit I/Q samples from NUM-bit mantissas
// and a per-PRB exponent, checks packet framing and keeps all sideband aligned over 3 stages.
module ul_decompress_bit #(
    parameter int NUM       = 7,
    parameter int PRB_LEN   = 12,
    parameter int MAX_SHIFT = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sel,
    input  logic              i_sop,
    input  logic              i_eop,
    input  logic              i_vld,
    input  logic [2*NUM-1:0]  i_din,
    input  logic [3:0]        i_shift,
    input  logic [6:0]        i_slot_idx,
    input  logic [3:0]        i_symb_idx,
    input  logic [8:0]        i_prb_idx,
    input  logic [3:0]        i_ch_type,
    input  logic [7:0]        i_info,
    output logic              o_sel,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_vld,
    output logic [31:0]       o_dout,
    output logic [6:0]        o_slot_idx,
    output logic [3:0]        o_symb_idx,
    output logic [8:0]        o_prb_idx,
    output logic [3:0]        o_type,
    output logic [7:0]        o_info,
    output logic              o_err,
    output logic [15:0]       o_err_cnt
);

    localparam int PAD = 16 - NUM;

    typedef enum logic {
        IDLE,
        BODY
    } state_t;

    typedef struct packed {
        logic       sel;
        logic       sop;
        logic       eop;
        logic       vld;
        logic       err;
        logic [6:0] slot;
        logic [3:0] symb;
        logic [8:0] prb;
        logic [3:0] typ;
        logic [7:0] info;
    } ctl_t;

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic [5:0] cnt_inc;
    logic [3:0] shift_hold, shift_hold_nxt;
    logic [3:0] shift_beat;
    logic [3:0] shift_clamped;
    logic       shift_bad;
    logic       beat_err;

    ctl_t             ctl_in, ctl1, ctl2;
    logic [2*NUM-1:0] s1_din;
    logic [3:0]       s1_shift;
    logic signed [15:0] exp_i, exp_q;
    logic signed [15:0] shr_i, shr_q;
    logic [31:0]      s2_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_hold <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shift_hold <= shift_hold_nxt;
        end
    end

    // A sop beat is decoded with its own (clamped) exponent; every other beat uses the held one.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        shift_hold_nxt = shift_hold;
        shift_beat     = shift_hold;
        beat_err       = 1'b0;
        cnt_inc        = {1'b0, cnt} + 6'd1;
        shift_bad      = (i_shift > 4'(MAX_SHIFT));
        shift_clamped  = shift_bad ? 4'(MAX_SHIFT) : i_shift;

        if (i_vld) begin
            if (i_sop) begin
                shift_beat     = shift_clamped;
                shift_hold_nxt = shift_clamped;
                beat_err       = shift_bad || (state == BODY);
                if (i_eop) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    if (PRB_LEN != 1) begin
                        beat_err = 1'b1;
                    end
                end else begin
                    state_nxt = BODY;
                    cnt_nxt   = 5'd1;
                end
            end else if (state == IDLE) begin
                beat_err = 1'b1;
            end else if (i_eop) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                if (cnt_inc != 6'(PRB_LEN)) begin
                    beat_err = 1'b1;
                end
            end else if (cnt_inc > 6'(PRB_LEN)) begin
                beat_err = 1'b1;
                cnt_nxt  = 5'(PRB_LEN);
            end else begin
                cnt_nxt = cnt_inc[4:0];
            end
        end
    end

    always_comb begin
        ctl_in.sel  = i_sel;
        ctl_in.sop  = i_sop;
        ctl_in.eop  = i_eop;
        ctl_in.vld  = i_vld;
        ctl_in.err  = beat_err;
        ctl_in.slot = i_slot_idx;
        ctl_in.symb = i_symb_idx;
        ctl_in.prb  = i_prb_idx;
        ctl_in.typ  = i_ch_type;
        ctl_in.info = i_info;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl1     <= '0;
            s1_din   <= '0;
            s1_shift <= '0;
        end else begin
            ctl1     <= ctl_in;
            s1_din   <= i_din;
            s1_shift <= shift_beat;
        end
    end

    // Mantissa is placed in the top bits so the arithmetic right shift restores magnitude.
    always_comb begin
        exp_i = signed'({s1_din[2*NUM-1 -: NUM], {PAD{1'b0}}});
        exp_q = signed'({s1_din[NUM-1:0], {PAD{1'b0}}});
        shr_i = exp_i >>> s1_shift;
        shr_q = exp_q >>> s1_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl2    <= '0;
            s2_dout <= '0;
        end else begin
            ctl2    <= ctl1;
            s2_dout <= {shr_i, shr_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sel      <= 1'b0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
            o_vld      <= 1'b0;
            o_err      <= 1'b0;
            o_dout     <= '0;
            o_slot_idx <= '0;
            o_symb_idx <= '0;
            o_prb_idx  <= '0;
            o_type     <= '0;
            o_info     <= '0;
            o_err_cnt  <= '0;
        end else begin
            o_sel      <= ctl2.sel;
            o_sop      <= ctl2.sop;
            o_eop      <= ctl2.eop;
            o_vld      <= ctl2.vld;
            o_err      <= ctl2.err;
            o_dout     <= ctl2.vld ? s2_dout : 32'd0;
            o_slot_idx <= ctl2.slot;
            o_symb_idx <= ctl2.symb;
            o_prb_idx  <= ctl2.prb;
            o_type     <= ctl2.typ;
            o_info     <= ctl2.info;
            if (ctl2.err && (o_err_cnt != 16'hFFFF)) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ul_decompress_bit.sv
// Bench for ul_decompress_bit: hand-computed vector table, directed corner sequences and
// random traffic, all checked against a packet-level reference model.
module tb_ul_decompress_bit;

    localparam int NUM     = 7;
    localparam int PRB_LEN = 12;
    localparam int MAXS    = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_sel = 1'b0, i_sop = 1'b0, i_eop = 1'b0, i_vld = 1'b0;
    logic [2*NUM-1:0]  i_din = '0;
    logic [3:0]        i_shift = '0;
    logic [6:0]        i_slot_idx = '0;
    logic [3:0]        i_symb_idx = '0;
    logic [8:0]        i_prb_idx = '0;
    logic [3:0]        i_ch_type = '0;
    logic [7:0]        i_info = '0;
    logic              o_sel, o_sop, o_eop, o_vld, o_err;
    logic [31:0]       o_dout;
    logic [6:0]        o_slot_idx;
    logic [3:0]        o_symb_idx;
    logic [8:0]        o_prb_idx;
    logic [3:0]        o_type;
    logic [7:0]        o_info;
    logic [15:0]       o_err_cnt;

    ul_decompress_bit #(.NUM(NUM), .PRB_LEN(PRB_LEN), .MAX_SHIFT(MAXS)) dut (
        .clk(clk), .rst(rst), .i_sel(i_sel), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
        .i_din(i_din), .i_shift(i_shift), .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx),
        .i_prb_idx(i_prb_idx), .i_ch_type(i_ch_type), .i_info(i_info),
        .o_sel(o_sel), .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld), .o_dout(o_dout),
        .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx), .o_prb_idx(o_prb_idx),
        .o_type(o_type), .o_info(o_info), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld, sop, eop;
        logic [13:0] din;
        logic [3:0]  shift;
        logic [31:0] hand_dout;
        logic        hand_err;
    } vec_t;

    typedef struct {
        logic        sel, sop, eop, vld, err;
        logic [31:0] dout;
        logic [6:0]  slot;
        logic [3:0]  symb;
        logic [8:0]  prb;
        logic [3:0]  typ;
        logic [7:0]  info;
        bit          has_hand;
        logic [31:0] hand_dout;
        logic        hand_err;
    } exp_t;

    vec_t  tbl[$];
    exp_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    bit          m_in_pkt;
    int          m_count;
    int          m_held;
    logic [15:0] m_err_cnt;

    function automatic vec_t mk(logic vld, logic sop, logic eop, logic [13:0] din,
                                logic [3:0] shift, logic [31:0] dout, logic err);
        vec_t v;
        v.vld = vld; v.sop = sop; v.eop = eop; v.din = din; v.shift = shift;
        v.hand_dout = dout; v.hand_err = err;
        return v;
    endfunction

    // Hand-entered packet: every beat decodes to the same value, only the last may be an error.
    function automatic void addPacket(int len, logic [3:0] shift, logic [13:0] din,
                                      logic [31:0] dout, logic last_err);
        for (int b = 0; b < len; b++)
            tbl.push_back(mk(1'b1, b == 0, b == len - 1, din, shift, dout,
                             (b == len - 1) ? last_err : 1'b0));
    endfunction

    function automatic logic [15:0] dec(logic [6:0] m, int sh);
        int v;
        v = int'($signed(m)) * (1 << (16 - NUM));
        v = v >>> sh;
        return v[15:0];
    endfunction

    // Packet-level reference: which exponent applies and whether the beat breaks framing.
    task automatic modelBeat(input vec_t v, output int sh, output logic err);
        err = 1'b0;
        if (v.sop) begin
            sh     = (int'(v.shift) > MAXS) ? MAXS : int'(v.shift);
            err    = (int'(v.shift) > MAXS) || m_in_pkt;
            m_held = sh;
            if (v.eop) begin
                m_in_pkt = 0;
                if (PRB_LEN != 1) err = 1'b1;
            end else begin
                m_in_pkt = 1;
                m_count  = 1;
            end
        end else begin
            sh = m_held;
            if (!m_in_pkt) begin
                err = 1'b1;
            end else if (v.eop) begin
                if (m_count + 1 != PRB_LEN) err = 1'b1;
                m_in_pkt = 0;
            end else if (m_count + 1 > PRB_LEN) begin
                err     = 1'b1;
                m_count = PRB_LEN;
            end else begin
                m_count++;
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [84:0] got, want;
        if (e.err && m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
        got  = {o_sel, o_sop, o_eop, o_vld, o_err, o_dout, o_slot_idx, o_symb_idx,
                o_prb_idx, o_type, o_info, o_err_cnt};
        want = {e.sel, e.sop, e.eop, e.vld, e.err, e.dout, e.slot, e.symb,
                e.prb, e.typ, e.info, m_err_cnt};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t got=%h want=%h (dout %h/%h err %b/%b cnt %0d/%0d)",
                     $time, got, want, o_dout, e.dout, o_err, e.err, o_err_cnt, m_err_cnt);
        end
        if (e.has_hand) begin
            vectors++;
            if (o_dout !== e.hand_dout || o_err !== e.hand_err || o_vld !== 1'b1 && e.vld) begin
                miscompares++;
                $display("[TB] FAIL hand t=%0t dout=%h want %h err=%b want %b",
                         $time, o_dout, e.hand_dout, o_err, e.hand_err);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit has_hand);
        exp_t e;
        int   sh;
        logic err;
        e = '{default: '0};
        i_vld = v.vld; i_sop = v.sop; i_eop = v.eop; i_din = v.din; i_shift = v.shift;
        i_sel = 1'($urandom); i_slot_idx = 7'($urandom); i_symb_idx = 4'($urandom);
        i_prb_idx = 9'($urandom); i_ch_type = 4'($urandom); i_info = 8'($urandom);
        e.sel = i_sel; e.sop = v.sop; e.eop = v.eop; e.vld = v.vld;
        e.slot = i_slot_idx; e.symb = i_symb_idx; e.prb = i_prb_idx;
        e.typ = i_ch_type; e.info = i_info;
        if (v.vld) begin
            modelBeat(v, sh, err);
            e.err  = err;
            e.dout = {dec(v.din[13:7], sh), dec(v.din[6:0], sh)};
        end
        e.has_hand = has_hand; e.hand_dout = v.hand_dout; e.hand_err = v.hand_err;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        checkOutput(exp_q.pop_front());
    endtask

    task automatic resetDut();
        exp_t z;
        z = '{default: '0};
        rst = 1'b1;
        i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_din = '0; i_shift = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_in_pkt = 0; m_count = 0; m_held = 0; m_err_cnt = '0;
        exp_q.delete();
        checkOutput(z);
        exp_q.push_back(z);
        exp_q.push_back(z);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++)
            applyStimulus(mk(1'b0, 1'b0, 1'b0, 14'($urandom), 4'($urandom), 32'd0, 1'b0), 1'b1);
    endtask

    initial begin
        // {I,Q} = {3F,40}; reference values worked out by hand from the shift rule
        addPacket(12, 4'd0, {7'h3F, 7'h40}, 32'h7E00_8000, 1'b0);
        addPacket(12, 4'd3, {7'h3F, 7'h40}, 32'h0FC0_F000, 1'b0);
        addPacket(12, 4'd9, {7'h01, 7'h7F}, 32'h0001_FFFF, 1'b0);
        addPacket(12, 4'd2, {7'h3F, 7'h40}, 32'h1F80_E000, 1'b0);
        addPacket(12, 4'd5, {7'h3F, 7'h40}, 32'h03F0_FC00, 1'b0);
        addPacket(11, 4'd0, {7'h3F, 7'h40}, 32'h7E00_8000, 1'b1);
        for (int b = 0; b < 4; b++)
            tbl.push_back(mk(1'b1, b == 0, 1'b0, {7'h3F, 7'h40}, 4'd1, 32'h3F00_C000, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, {7'h3F, 7'h40}, 4'd4, 32'h07E0_F800, 1'b1));
        for (int b = 1; b < 12; b++)
            tbl.push_back(mk(1'b1, 1'b0, b == 11, {7'h3F, 7'h40}, 4'd0, 32'h07E0_F800, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 14'h1234, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, {7'h3F, 7'h40}, 4'd0, 32'h07E0_F800, 1'b1));

        resetDut();
        resetDut();
        foreach (tbl[n]) applyStimulus(tbl[n], 1'b1);
        idle(3);
        vectors++;
        if (o_err_cnt !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL err_cnt_after_table got %0d want 3", o_err_cnt);
        end

        $display("[TB] clamp and gap sequences");
        applyStimulus(mk(1'b1, 1'b1, 1'b0, {7'h01, 7'h7F}, 4'hC, 32'h0001_FFFF, 1'b1), 1'b1);
        for (int b = 1; b < 12; b++)
            applyStimulus(mk(1'b1, 1'b0, b == 11, {7'h01, 7'h7F}, 4'hF, 32'h0001_FFFF, 1'b0), 1'b1);
        for (int b = 0; b < 12; b++) begin
            applyStimulus(mk(1'b1, b == 0, b == 11, {7'h3F, 7'h40}, 4'd2, 32'h1F80_E000, 1'b0), 1'b1);
            if (b < 11) idle(1 + (b % 4));
        end
        idle(3);

        $display("[TB] reset mid-packet");
        for (int b = 0; b < 5; b++)
            applyStimulus(mk(1'b1, b == 0, 1'b0, {7'h3F, 7'h40}, 4'd0, 32'h7E00_8000, 1'b0), 1'b1);
        resetDut();
        vectors++;
        if (o_err_cnt !== 16'd0 || o_vld !== 1'b0 || o_dout !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_flush cnt=%0d vld=%b dout=%h want 0", o_err_cnt, o_vld, o_dout);
        end
        idle(2);
        for (int b = 0; b < 12; b++)
            applyStimulus(mk(1'b1, b == 0, b == 11, {7'h3F, 7'h40}, 4'd3, 32'h0FC0_F000, 1'b0), 1'b1);
        idle(3);

        $display("[TB] random traffic");
        for (int k = 0; k < 1500; k++) begin
            vec_t v;
            if ($urandom_range(0, 299) == 0) begin
                resetDut();
            end else begin
                v = mk($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 12) == 0, 14'($urandom), 4'($urandom_range(0, 15)),
                       32'd0, 1'b0);
                applyStimulus(v, 1'b0);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
